// File: rtl/cache_pkg.sv
// Shared geometry, state encoding and line type for the direct-mapped L1 data cache.
package cache_pkg;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_NUM_LINES = 32;
    localparam int DEF_LINE_BITS = 256;

    localparam int WORD_W   = 32;
    localparam int OFFSET_W = 5;
    localparam int WSEL_W   = OFFSET_W - 2;
    localparam int INDEX_W  = $clog2(DEF_NUM_LINES);
    localparam int TAG_W    = DEF_ADDR_W - INDEX_W - OFFSET_W;

    typedef logic [DEF_LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        REFILL    = 2'd3
    } state_e;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the data cache: one combinational read port,
// one write port that either fills a whole line or merges a single word.
module dcache_sram
    import cache_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int IDX_W     = INDEX_W,
    parameter int TAG_BITS  = TAG_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_W-1:0]     rd_idx_i,
    output logic [TAG_BITS-1:0]  rd_tag_o,
    output logic                 rd_valid_o,
    output logic                 rd_dirty_o,
    output logic [LINE_BITS-1:0] rd_line_o,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic                 fill_en_i,
    input  logic [TAG_BITS-1:0]  fill_tag_i,
    input  logic [LINE_BITS-1:0] fill_line_i,
    input  logic                 merge_en_i,
    input  logic [WSEL_W-1:0]    merge_wsel_i,
    input  logic [WORD_W-1:0]    merge_data_i
);

    logic [LINE_BITS-1:0] data_q [NUM_LINES];
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_line_o  = data_q[rd_idx_i];

    // NOTE: data and tags carry no reset -- they are meaningless until valid is set, and leaving them unreset keeps them mappable to plain RAM.
    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            data_q[wr_idx_i] <= fill_line_i;
            tag_q[wr_idx_i]  <= fill_tag_i;
        end else if (merge_en_i) begin
            data_q[wr_idx_i][{merge_wsel_i, 5'b0} +: WORD_W] <= merge_data_i;
        end
    end

    // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            dirty_q[wr_idx_i] <= 1'b0;
        end else if (merge_en_i) begin
            dirty_q[wr_idx_i] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 data cache controller with miss FSM.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
    import cache_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 wr_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [WORD_W-1:0]    wdata_i,
    output logic [WORD_W-1:0]    rdata_o,
    output logic                 stall_o,
    output logic                 mem_req_o,
    output logic                 mem_wr_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
`endif
);

    localparam int IDX_W    = $clog2(NUM_LINES);
    localparam int TAG_BITS = ADDR_W - IDX_W - OFFSET_W;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx;
    logic [TAG_BITS-1:0]   tag;
    logic [WSEL_W-1:0]     wsel;
    logic [TAG_BITS-1:0]   rd_tag;
    logic                  rd_valid;
    logic                  rd_dirty;
    logic [LINE_BITS-1:0]  rd_line;
    logic [WORD_W-1:0]     rd_word;
    logic                  hit;
    logic                  stall_c;
    logic                  fill_en;
    logic                  merge_en;
    logic                  unused_addr_lsb;

    assign idx             = addr_i[OFFSET_W +: IDX_W];
    assign tag             = addr_i[ADDR_W-1 -: TAG_BITS];
    assign wsel            = addr_i[OFFSET_W-1:2];
    assign unused_addr_lsb = ^addr_i[1:0];

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .LINE_BITS (LINE_BITS),
        .IDX_W     (IDX_W),
        .TAG_BITS  (TAG_BITS)
    ) u_sram (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rd_idx_i     (idx),
        .rd_tag_o     (rd_tag),
        .rd_valid_o   (rd_valid),
        .rd_dirty_o   (rd_dirty),
        .rd_line_o    (rd_line),
        .wr_idx_i     (idx),
        .fill_en_i    (fill_en),
        .fill_tag_i   (tag),
        .fill_line_i  (mem_rdata_i),
        .merge_en_i   (merge_en),
        .merge_wsel_i (wsel),
        .merge_data_i (wdata_i)
    );

    assign rd_word = rd_line[{wsel, 5'b0} +: WORD_W];
    assign hit     = req_i & rd_valid & (rd_tag == tag);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no branch can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        stall_c     = 1'b0;
        fill_en     = 1'b0;
        merge_en    = 1'b0;
        rdata_o     = '0;
        mem_req_o   = 1'b0;
        mem_wr_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    merge_en = wr_i;
                    rdata_o  = wr_i ? '0 : rd_word;
                end else if (req_i) begin
                    stall_c = 1'b1;
                    state_d = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            // Victim is still resident at this index until the fill, so the read port supplies it.
            WRITEBACK: begin
                stall_c     = 1'b1;
                mem_req_o   = 1'b1;
                mem_wr_o    = 1'b1;
                mem_addr_o  = {rd_tag, idx, {OFFSET_W{1'b0}}};
                mem_wdata_o = rd_line;
                if (mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                stall_c    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {tag, idx, {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    fill_en = 1'b1;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (hit) begin
                    merge_en = wr_i;
                    rdata_o  = wr_i ? '0 : rd_word;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A held request misses against the cleared valid bits while reset is low; keep the pipeline unfrozen.
    assign stall_o = stall_c & rst_i;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        count_hit;
    logic        count_miss;

    assign count_hit  = (state_q == IDLE) && hit;
    assign count_miss = (state_q == IDLE) && req_i && !hit;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (count_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (count_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed miss/hit/eviction/reset steps, then
// random accesses scored against an abstract cache + backing-memory model.
module tb_dcache_ctrl;
    import cache_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_i;
    logic          wr_i;
    logic [31:0]   addr_i;
    logic [31:0]   wdata_i;
    logic [31:0]   rdata_o;
    logic          stall_o;
    logic          mem_req_o;
    logic          mem_wr_o;
    logic [31:0]   mem_addr_o;
    logic [255:0]  mem_wdata_o;
    logic [255:0]  mem_rdata_i;
    logic          mem_ack_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]   hit_cnt_o;
    logic [31:0]   miss_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    dcache_ctrl #(
        .NUM_LINES (32),
        .LINE_BITS (256),
        .ADDR_W    (32)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .wr_i        (wr_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_wr_o    (mem_wr_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Abstract model: cache contents per index plus a sparse backing memory.
    logic        m_valid [32];
    logic        m_dirty [32];
    logic [21:0] m_tag   [32];
    logic [31:0] m_data  [32][8];
    logic [31:0] bmem    [logic [31:0]];
    int          n_hit;
    int          n_miss;

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return 32'h0000_0FF0 + (a >> 2);
    endfunction

    function automatic line_t model_line(input logic [4:0] idx);
        line_t l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = m_data[idx][i];
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        n_hit  = 0;
        n_miss = 0;
    endtask

    // One memory transaction: hold-stable checks every cycle, ack after a random latency.
    task automatic mem_phase(input logic is_wb, input logic [31:0] exp_addr,
                             input line_t exp_line, input line_t fill_line);
        int lat;
        lat = $urandom_range(1, 4);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk_i);
            check("miss_stall", stall_o, 1'b1);
            check("mem_req", mem_req_o, 1'b1);
            check("mem_wr", mem_wr_o, is_wb);
            check("mem_addr", mem_addr_o, exp_addr);
            if (is_wb) check("wb_data", mem_wdata_o, exp_line);
            mem_rdata_i = (c == lat && !is_wb) ? fill_line : {8{$urandom}};
            mem_ack_i   = (c == lat);
            @(posedge clk_i); #1;
            mem_ack_i   = 1'b0;
        end
    endtask

    // Entered just after a rising edge; leaves just after the edge that retires the access.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [4:0]  idx;
        logic [21:0] tg;
        logic [2:0]  ws;
        logic        hit;
        line_t       fill;
        idx = a[9:5];
        tg  = a[31:10];
        ws  = a[4:2];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        req_i = 1'b1; wr_i = w; addr_i = a; wdata_i = d;
        @(negedge clk_i);
        check("first_stall", stall_o, !hit);
        if (hit) begin
            n_hit++;
            check("hit_mem_req", mem_req_o, 1'b0);
            if (!w) check("hit_rdata", rdata_o, m_data[idx][ws]);
            @(posedge clk_i); #1;
        end else begin
            n_miss++;
            @(posedge clk_i); #1;
            if (m_valid[idx] && m_dirty[idx]) begin
                mem_phase(1'b1, {m_tag[idx], idx, 5'b0}, model_line(idx), '0);
                for (int i = 0; i < 8; i++) bmem[{m_tag[idx], idx, 5'b0} + 32'(i*4)] = m_data[idx][i];
            end
            for (int i = 0; i < 8; i++) begin
                m_data[idx][i]  = mem_word({tg, idx, 5'b0} + 32'(i*4));
                fill[i*32 +: 32] = m_data[idx][i];
            end
            mem_phase(1'b0, {tg, idx, 5'b0}, '0, fill);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
            @(negedge clk_i);
            check("refill_stall", stall_o, 1'b0);
            check("refill_mem_req", mem_req_o, 1'b0);
            if (!w) check("refill_rdata", rdata_o, m_data[idx][ws]);
            @(posedge clk_i); #1;
        end
        if (w) begin
            m_data[idx][ws] = d;
            m_dirty[idx]    = 1'b1;
        end
        req_i = 1'b0;
    endtask

    // Idle cycles with stray acks that must be ignored.
    task automatic idle(input int n);
        req_i = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk_i);
            check("idle_stall", stall_o, 1'b0);
            check("idle_mem_req", mem_req_o, 1'b0);
            mem_ack_i = ($urandom_range(0, 1) == 1);
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
        end
    endtask

    task automatic check_stats();
`ifdef DCACHE_STATS_EN
        check("hit_cnt", hit_cnt_o, 32'(n_hit));
        check("miss_cnt", miss_cnt_o, 32'(n_miss));
`endif
    endtask

    initial begin
        logic [31:0] a;
        rst_i = 1'b0; req_i = 1'b0; wr_i = 1'b0; addr_i = '0; wdata_i = '0;
        mem_rdata_i = '0; mem_ack_i = 1'b0;
        model_reset();
        #12;
        check("rst_stall", stall_o, 1'b0);
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_mem_wr", mem_wr_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        idle(2);
        check_stats();

        access(1'b0, 32'h0000_0040, 32'h0);
        access(1'b0, 32'h0000_0044, 32'h0);
        access(1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        access(1'b0, 32'h0000_0440, 32'h0);
        access(1'b1, 32'h0000_0080, 32'hCAFE_0001);
        access(1'b0, 32'h0000_0080, 32'h0);
        idle(2);
        check_stats();

        // Reset lands while the fill for 0x40 is outstanding.
        req_i = 1'b1; wr_i = 1'b0; addr_i = 32'h0000_0040;
        @(negedge clk_i);
        check("pre_rst_stall", stall_o, 1'b1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("pre_rst_req", mem_req_o, 1'b1);
        check("pre_rst_addr", mem_addr_o, 32'h0000_0040);
        #2 rst_i = 1'b0;
        #1;
        check("mid_rst_req", mem_req_o, 1'b0);
        check("mid_rst_stall", stall_o, 1'b0);
        check("mid_rst_mem_wr", mem_wr_o, 1'b0);
        check("mid_rst_rdata", rdata_o, 32'h0);
        model_reset();
        check_stats();
        @(posedge clk_i); #1;
        req_i = 1'b0;
        rst_i = 1'b1;
        idle(1);
        access(1'b0, 32'h0000_0040, 32'h0);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5)
              | (32'($urandom_range(0, 7)) << 2);
            access(($urandom_range(0, 1) == 1), a, $urandom);
        end
        idle(1);
        check_stats();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
